sd_block_seq: RTL

//  Autonomous multi-byte sequencer for the SD-card SPI byte shifter. CPU programs a byte count and

---
 rtl/sd_block_seq_pkg.sv | 50 +++++
 rtl/sd_seq_fifo.sv | 76 +++++++
 rtl/sd_block_seq.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_block_seq_pkg.sv
// Shared definitions for the SD-card block sequencer: register offsets,
// CTRL/STAT bit positions, FSM states, start token and (with SD_CRC16_EN)
// the CRC-16/CCITT byte update.
package sd_block_seq_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;  // W: CTRL, R: STAT
  localparam logic [2:0] REG_CNT_LO = 3'd1;
  localparam logic [2:0] REG_CNT_HI = 3'd2;
  localparam logic [2:0] REG_DATA   = 3'd3;
  localparam logic [2:0] REG_RXLVL  = 3'd4;
  localparam logic [2:0] REG_TXLVL  = 3'd5;
  localparam logic [2:0] REG_CRC_HI = 3'd6;
  localparam logic [2:0] REG_CRC_LO = 3'd7;

  localparam int unsigned CTRL_GO     = 0;
  localparam int unsigned CTRL_DIR    = 1;
  localparam int unsigned CTRL_HUNT   = 2;
  localparam int unsigned CTRL_IRQ_EN = 3;
  localparam int unsigned CTRL_ABORT  = 7;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_RXNE    = 1;
  localparam int unsigned STAT_TXNF    = 2;
  localparam int unsigned STAT_TIMEOUT = 3;
  localparam int unsigned STAT_DONE    = 4;
  localparam int unsigned STAT_IRQ_EN  = 5;

  localparam logic [7:0] START_TOKEN = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_HWAIT,
    ST_ISSUE,
    ST_WAIT
  } seq_state_t;

`ifdef SD_CRC16_EN
  // CRC-16/CCITT (poly 0x1021), MSB first, one byte per call
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {d, 8'h00};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/sd_seq_fifo.sv
// Small synchronous FIFO used for the sequencer's TX and RX byte queues.
// Updates on the falling clock edge like the rest of the sequencer.
// Push on full is dropped; pop on empty returns the last popped byte.
module sd_seq_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    wr_data,
  input  logic          pop,
  output logic [7:0]    rd_data,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int unsigned AW = LW - 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [LW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    last_q, last_d;
  logic          do_push, do_pop;
  logic [AW-1:0] wr_idx, rd_idx;

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (level == LW'(DEPTH));
  assign rd_data = empty ? last_q : mem_q[rd_idx];

  // Pointer/memory next state; a simultaneous pop lets a push into a full
  // FIFO through, and a push lets a pop on an empty FIFO consume it.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    do_push  = push & (~full | pop);
    do_pop   = pop & (~empty | push);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_idx] = wr_data;
        wr_ptr_d      = wr_ptr_q + LW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + LW'(1);
        last_d   = empty ? wr_data : mem_q[rd_idx];
      end
    end
  end

  // State registers
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      last_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/sd_block_seq.sv
// SD-card SPI block sequencer: issues back-to-back byte transfers to the
// SPI shifter from a programmed count, buffering TX/RX bytes in FIFOs, with
// optional 0xFE start-token hunt before reads.
// Optional feature macro: SD_CRC16_EN (CRC-16 over data bytes at offsets 6/7).
module sd_block_seq
  import sd_block_seq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TOKEN_TRIES = 256,
  parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
  input  logic       E,
  input  logic       nRESET,
  input  logic       REG_SEL,
  input  logic [2:0] REG_ADDR,
  input  logic       RnW,
  input  logic [7:0] DATA_in,
  output logic [7:0] DATA_out,
  output logic       SPI_START,
  output logic [7:0] SPI_TX,
  input  logic       SPI_BUSY,
  input  logic       SPI_DONE,
  input  logic [7:0] SPI_RX,
  output logic       SEQ_IRQ
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TOKEN_TRIES + 1);

  seq_state_t    state_q, state_d;
  logic          spi_start_q, spi_start_d;
  logic [7:0]    spi_tx_q, spi_tx_d;
  logic [10:0]   remaining_q, remaining_d;
  logic [TW-1:0] tries_q, tries_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;
  logic          abort_pend_q, abort_pend_d;
  logic          dir_q, dir_d;
  logic          irq_en_q, irq_en_d;
  logic [7:0]    cnt_lo_q, cnt_lo_d;
  logic [1:0]    cnt_hi_q, cnt_hi_d;
`ifdef SD_CRC16_EN
  logic [15:0]   crc_q, crc_d;
`endif

  logic          wr_acc, rd_acc, ctrl_wr, stat_rd;
  logic          abort_req, go_req;
  logic          tx_push_cpu, rx_pop_cpu;
  logic          flush, tx_pop, rx_push;
  logic [10:0]   cnt_load;
  logic [7:0]    stat;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [7:0]    tx_head, rx_head;
  logic [LW-1:0] tx_level, rx_level;

  // The shifter's busy flag is implied by the WAIT state; kept as a port only.
  logic unused_busy;
  assign unused_busy = SPI_BUSY;

  assign wr_acc      = REG_SEL & ~RnW;
  assign rd_acc      = REG_SEL & RnW;
  assign ctrl_wr     = wr_acc & (REG_ADDR == REG_CTRL);
  assign stat_rd     = rd_acc & (REG_ADDR == REG_CTRL);
  assign abort_req   = ctrl_wr & DATA_in[CTRL_ABORT];
  assign go_req      = ctrl_wr & DATA_in[CTRL_GO] & ~DATA_in[CTRL_ABORT] & (state_q == ST_IDLE);
  assign tx_push_cpu = wr_acc & (REG_ADDR == REG_DATA);
  assign rx_pop_cpu  = rd_acc & (REG_ADDR == REG_DATA);
  assign cnt_load    = ({cnt_hi_q, cnt_lo_q} == 10'd0) ? 11'd1024 : {1'b0, cnt_hi_q, cnt_lo_q};

  assign SPI_START = spi_start_q;
  assign SPI_TX    = spi_tx_q;
  assign SEQ_IRQ   = (done_q | timeout_q) & irq_en_q;

  sd_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk     (E),
    .rst_n   (nRESET),
    .flush   (flush),
    .push    (tx_push_cpu),
    .wr_data (DATA_in),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty),
    .level   (tx_level)
  );

  sd_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk     (E),
    .rst_n   (nRESET),
    .flush   (flush),
    .push    (rx_push),
    .wr_data (SPI_RX),
    .pop     (rx_pop_cpu),
    .rd_data (rx_head),
    .full    (rx_full),
    .empty   (rx_empty),
    .level   (rx_level)
  );

  // CPU-writable configuration registers
  always_comb begin
    cnt_lo_d = cnt_lo_q;
    cnt_hi_d = cnt_hi_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) irq_en_d = DATA_in[CTRL_IRQ_EN];
    if (wr_acc && (REG_ADDR == REG_CNT_LO)) cnt_lo_d = DATA_in;
    if (wr_acc && (REG_ADDR == REG_CNT_HI)) cnt_hi_d = DATA_in[1:0];
  end

  // Sequencer FSM: next state, shifter handshake, FIFO strobes, status flags.
  // An abort during an in-flight byte is parked in abort_pend until SPI_DONE.
  always_comb begin
    state_d      = state_q;
    spi_start_d  = 1'b0;
    spi_tx_d     = spi_tx_q;
    remaining_d  = remaining_q;
    tries_d      = tries_q;
    dir_d        = dir_q;
    abort_pend_d = abort_pend_q;
    done_d       = done_q & ~stat_rd;
    timeout_d    = timeout_q & ~stat_rd;
    flush        = 1'b0;
    tx_pop       = 1'b0;
    rx_push      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        abort_pend_d = 1'b0;
        if (abort_req) begin
          flush = 1'b1;
        end else if (go_req) begin
          dir_d       = DATA_in[CTRL_DIR];
          remaining_d = cnt_load;
          tries_d     = '0;
          state_d     = (DATA_in[CTRL_HUNT] && !DATA_in[CTRL_DIR]) ? ST_HUNT : ST_ISSUE;
        end
      end
      ST_HUNT: begin
        if (abort_req) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          spi_start_d = 1'b1;
          spi_tx_d    = FILL_BYTE;
          state_d     = ST_HWAIT;
        end
      end
      ST_HWAIT: begin
        if (abort_req) abort_pend_d = 1'b1;
        if (SPI_DONE) begin
          if (abort_pend_q || abort_req) begin
            flush        = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
          end else if (SPI_RX == START_TOKEN) begin
            state_d = ST_ISSUE;
          end else if (tries_q == TW'(TOKEN_TRIES - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            tries_d = tries_q + TW'(1);
            state_d = ST_HUNT;
          end
        end
      end
      ST_ISSUE: begin
        if (abort_req) begin
          flush   = 1'b1;
          state_d = ST_IDLE;
        end else if (dir_q) begin
          if (!tx_empty) begin
            tx_pop      = 1'b1;
            spi_start_d = 1'b1;
            spi_tx_d    = tx_head;
            state_d     = ST_WAIT;
          end
        end else if (!rx_full) begin
          spi_start_d = 1'b1;
          spi_tx_d    = FILL_BYTE;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (abort_req) abort_pend_d = 1'b1;
        if (SPI_DONE) begin
          if (abort_pend_q || abort_req) begin
            flush        = 1'b1;
            abort_pend_d = 1'b0;
            state_d      = ST_IDLE;
          end else begin
            rx_push     = ~dir_q;
            remaining_d = remaining_q - 11'd1;
            if (remaining_q == 11'd1) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_ISSUE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SD_CRC16_EN
  // CRC over data bytes only: popped TX bytes in write mode, pushed RX bytes in read mode
  always_comb begin
    crc_d = crc_q;
    if (go_req)       crc_d = '0;
    else if (tx_pop)  crc_d = crc16_byte(crc_q, tx_head);
    else if (rx_push) crc_d = crc16_byte(crc_q, SPI_RX);
  end

  // CRC register
  always_ff @(negedge E or negedge nRESET) begin
    if (!nRESET) crc_q <= '0;
    else         crc_q <= crc_d;
  end
`endif

  // CPU read mux (combinational)
  always_comb begin
    stat               = '0;
    stat[STAT_BUSY]    = (state_q != ST_IDLE);
    stat[STAT_RXNE]    = ~rx_empty;
    stat[STAT_TXNF]    = ~tx_full;
    stat[STAT_TIMEOUT] = timeout_q;
    stat[STAT_DONE]    = done_q;
    stat[STAT_IRQ_EN]  = irq_en_q;
    DATA_out           = '0;
    unique case (REG_ADDR)
      REG_CTRL:   DATA_out = stat;
      REG_CNT_LO: DATA_out = cnt_lo_q;
      REG_CNT_HI: DATA_out = {6'b0, cnt_hi_q};
      REG_DATA:   DATA_out = rx_head;
      REG_RXLVL:  DATA_out = 8'(rx_level);
      REG_TXLVL:  DATA_out = 8'(tx_level);
`ifdef SD_CRC16_EN
      REG_CRC_HI: DATA_out = crc_q[15:8];
      REG_CRC_LO: DATA_out = crc_q[7:0];
`else
      REG_CRC_HI: DATA_out = '0;
      REG_CRC_LO: DATA_out = '0;
`endif
      default:    DATA_out = '0;
    endcase
  end

  // Sequencer state registers
  always_ff @(negedge E or negedge nRESET) begin
    if (!nRESET) begin
      state_q      <= ST_IDLE;
      spi_start_q  <= 1'b0;
      spi_tx_q     <= FILL_BYTE;
      remaining_q  <= '0;
      tries_q      <= '0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      dir_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      cnt_lo_q     <= '0;
      cnt_hi_q     <= '0;
    end else begin
      state_q      <= state_d;
      spi_start_q  <= spi_start_d;
      spi_tx_q     <= spi_tx_d;
      remaining_q  <= remaining_d;
      tries_q      <= tries_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      abort_pend_q <= abort_pend_d;
      dir_q        <= dir_d;
      irq_en_q     <= irq_en_d;
      cnt_lo_q     <= cnt_lo_d;
      cnt_hi_q     <= cnt_hi_d;
    end
  end

endmodule
